// File: rtl/adder_reduce_ctrl.sv
// adder_reduce_ctrl: sequences operand beats through the shared 16-lane adder
// tree and folds each 20-bit reduced result into a saturating signed accumulator.
module adder_reduce_ctrl #(
  parameter int ACC_W = 32,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [255:0]     in_data,
  output logic [255:0]     add_in,
  input  logic [19:0]      add_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_sat
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t           state_q;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [LEN_W-1:0] cnt_q;
  logic             sat_q, ovf_d;
  logic             in_ready_q, out_valid_q, busy_q;
  logic [ACC_W:0]   sum_w;

  // The tree is fed straight from the operand bus; it is don't-care outside RUN.
  assign add_in    = in_data;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_data  = acc_q;
  assign out_sat   = sat_q;

  // Saturating accumulate: one guard bit catches overflow in either direction.
  always_comb begin
    sum_w = {acc_q[ACC_W-1], acc_q} + {{(ACC_W-19){add_out[19]}}, add_out};
    ovf_d = sum_w[ACC_W] ^ sum_w[ACC_W-1];
    acc_d = sum_w[ACC_W-1:0];
    if (ovf_d) acc_d = sum_w[ACC_W] ? ACC_MIN : ACC_MAX;
  end

  // Command FSM with registered handshake outputs; abort overrides everything.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (abort) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          acc_q  <= '0;
          sat_q  <= 1'b0;
          busy_q <= 1'b1;
          if (len != '0) begin
            state_q    <= RUN;
            cnt_q      <= len;
            in_ready_q <= 1'b1;
          end else begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        RUN: if (in_valid) begin
          acc_q <= acc_d;
          sat_q <= sat_q | ovf_d;
          cnt_q <= cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            state_q     <= DONE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b1;
          end
        end
        DONE: if (out_ready) begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/adder_reduce_ctrl.md
# adder_reduce_ctrl

Sequencer for the shared 16-lane adder-tree reducer in the systolic-array datapath. It accepts a start command with a beat count, then streams that many 256-bit operand beats (16 x 16-bit lanes) through the external adder tree. It accumulates each 20-bit reduced result into a saturating signed accumulator and presents the final sum on a valid/ready output. It sits between the PE output collector and the writeback path, and owns the adder tree's input bus.

## Interface
- ACC_W, 32: accumulator and result width (signed), must be >= 20
- LEN_W, 8: width of the beat-count field
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  command strobe; sampled only in IDLE
- len  input  LEN_W  number of beats for this command, unsigned; 0 is legal
- abort  input  1  synchronous abort; returns to IDLE from any state
- busy  output  1  high in RUN or DONE
- in_valid  input  1  operand beat valid
- in_ready  output  1  controller accepts a beat
- in_data  input  256  operand beat; lane i = bits [16i+15:16i]
- add_in  output  256  drive to the adder tree input; equals in_data combinationally
- add_out  input  20  signed adder-tree result for add_in, combinational, same cycle
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_data  output  ACC_W  signed accumulated result
- out_sat  output  1  saturation occurred during this command (valid with out_valid)

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=0, out_valid=0. start=1 and len!=0 -> RUN; acc<=0, cnt<=len, sat<=0. start=1 and len==0 -> DONE; acc<=0, sat<=0.
- RUN: in_ready=1. A beat is accepted on a clock edge with in_valid&&in_ready. On acceptance: acc<=sat(acc + sext(add_out)), cnt<=cnt-1, and sat<=sat|overflow. If cnt==1, next state is DONE.
- DONE: out_valid=1, out_data=acc, out_sat=sat. out_ready=1 -> IDLE. Both acc and sat hold until then.
- Arithmetic: add_out is sign-extended to ACC_W+1 bits and added to acc.
  - Result > 2^(ACC_W-1)-1: clamp to max and set overflow.
  - Result < -2^(ACC_W-1): clamp to min and set overflow.
  - add_out is trusted as produced, including rounding/scaling inside the adder tree; no further rounding here.
- abort=1 in any state -> IDLE next edge. It discards acc, cnt and any pending result; out_valid falls next cycle. abort has priority over start, beat acceptance and out_ready.
- start in RUN/DONE is ignored, with no queueing.
- add_in is always in_data, including outside RUN; the adder tree is don't-care when in_ready=0.

## Timing
- Reset (async, reset_n=0): state=IDLE, acc=0, cnt=0, sat=0, in_ready=0, out_valid=0, out_data=0, out_sat=0, busy=0. Release is synchronous to clk.
- start accepted at edge t: in_ready=1 from cycle t+1.
- Throughput is 1 beat/cycle; in_valid may gap arbitrarily.
- Last beat accepted at edge t: out_valid=1 in cycle t+1. With out_ready held high, IDLE at t+2.
- len==0: out_valid=1 in cycle t+1 after start, with out_data=0.
- Minimum command period: len+2 cycles. start is accepted in the IDLE cycle after the handshake.
- out_data and out_sat are stable while out_valid=1 and out_ready=0.
- Adder path is combinational: in_data -> add_in -> add_out -> acc must close in one clk period.

## Test plan
- Reset mid-RUN (reset_n low after 2 of 5 beats) -> all outputs at reset values immediately. A new command with len=3 and three beats of add_out=+10 -> out_data=30, out_sat=0.
- len=4, add_out values +100, -40, +7, -3 with in_valid gapped (1,0,1,1,0,1) -> in_ready high 4 accepted beats. out_valid exactly one cycle after the 4th acceptance, out_data=64.
- ACC_W=20 instance, len=3, add_out=+524287 each beat -> out_data=524287, out_sat=1. Repeat with -524288 -> out_data=-524288, out_sat=1.
- len=0 start -> out_valid the next cycle, out_data=0, in_ready never asserted.
- out_ready held low 5 cycles in DONE -> out_data and out_valid stable. A start pulse during that window is ignored. After release, the next start is accepted normally.
- abort asserted with in_valid=1 in RUN after 2 beats -> beat not accepted, IDLE next cycle. Then len=2 with add_out=+1,+1 -> out_data=2, with no residue from the aborted command.
